// File: rtl/ser_pkg.sv
// Shared types and constants for the serial bit feeder that drives the
// bit-serial sequence detectors.
package ser_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } ser_state_t;

    localparam int SER_WIDTH_DEF = 8;

    localparam bit SER_LSB_FIRST = 1'b0;
    localparam bit SER_MSB_FIRST = 1'b1;

endpackage

// File: rtl/serial_bit_feeder.sv
// Parallel-to-serial feeder: accepts WIDTH-bit words on valid/ready and emits
// them one bit per clock, with a one-word hold buffer for gapless streaming.
module serial_bit_feeder
    import ser_pkg::*;
#(
    parameter int WIDTH     = SER_WIDTH_DEF,
    parameter bit MSB_FIRST = SER_MSB_FIRST
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             ser_out,
    output logic             ser_valid,
    output logic             ser_first,
    output logic             ser_last
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    ser_state_t       state, nxt_state;
    logic [CW-1:0]    cnt, nxt_cnt;
    logic [WIDTH-1:0] sh, nxt_sh;
    logic [WIDTH-1:0] hold, nxt_hold;
    logic             hold_full, nxt_hold_full;
    logic             accept;
    logic             free;

    // Words are stored already in transmit order, so bit cnt is always sent next.
    function automatic logic [WIDTH-1:0] to_tx_order(input logic [WIDTH-1:0] w);
        logic [WIDTH-1:0] r;
        for (int i = 0; i < WIDTH; i++) begin
            r[i] = MSB_FIRST ? w[WIDTH-1-i] : w[i];
        end
        return r;
    endfunction

    assign in_ready = rst & ~hold_full;
    assign accept   = in_valid & in_ready;
    assign free     = (state == IDLE) || (cnt == CNT_LAST);

    always_comb begin
        nxt_state     = state;
        nxt_cnt       = cnt;
        nxt_sh        = sh;
        nxt_hold      = hold;
        nxt_hold_full = hold_full;
        if (free) begin
            nxt_cnt = '0;
            if (hold_full) begin
                nxt_sh        = hold;
                nxt_hold_full = 1'b0;
                nxt_state     = SHIFT;
            end else if (accept) begin
                nxt_sh    = to_tx_order(in_data);
                nxt_state = SHIFT;
            end else begin
                nxt_state = IDLE;
            end
        end else begin
            nxt_cnt = cnt + CW'(1);
            if (accept) begin
                nxt_hold      = to_tx_order(in_data);
                nxt_hold_full = 1'b1;
            end
        end
    end

    // Output flops are loaded from next-state values so the first bit of a
    // word appears in the cycle right after the edge that loads it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            cnt       <= '0;
            hold_full <= 1'b0;
            ser_out   <= 1'b0;
            ser_valid <= 1'b0;
            ser_first <= 1'b0;
            ser_last  <= 1'b0;
        end else begin
            state     <= nxt_state;
            cnt       <= nxt_cnt;
            hold_full <= nxt_hold_full;
            ser_valid <= (nxt_state == SHIFT);
            ser_out   <= (nxt_state == SHIFT) & nxt_sh[nxt_cnt];
            ser_first <= (nxt_state == SHIFT) && (nxt_cnt == '0);
            ser_last  <= (nxt_state == SHIFT) && (nxt_cnt == CNT_LAST);
        end
    end

    always_ff @(posedge clk) begin
        sh   <= nxt_sh;
        hold <= nxt_hold;
    end

endmodule

// File: tb/tb_serial_bit_feeder.sv
// Bench for serial_bit_feeder: MSB-first and LSB-first instances share one
// input stream and are checked every cycle against a bit-queue model.
module tb_serial_bit_feeder;

    localparam int W = 8;

    typedef struct packed {
        logic b;
        logic f;
        logic l;
    } sbit_t;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [W-1:0] in_data = '0;
    logic         in_valid = 1'b0;
    logic         rdy_m, out_m, v_m, f_m, l_m;
    logic         rdy_l, out_l, v_l, f_l, l_l;

    int    errors = 0;
    int    checks = 0;
    sbit_t qm[$];
    sbit_t ql[$];
    sbit_t exp_m, exp_l;
    logic  exp_v = 1'b0;
    logic [W-1:0] got_m, got_l;

    int         det_hits = 0;
    int         det_n = 0;
    logic [1:0] det_h = '0;

    serial_bit_feeder #(.WIDTH(W), .MSB_FIRST(1'b1)) u_msb (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
        .in_ready(rdy_m), .ser_out(out_m), .ser_valid(v_m),
        .ser_first(f_m), .ser_last(l_m)
    );

    serial_bit_feeder #(.WIDTH(W), .MSB_FIRST(1'b0)) u_lsb (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
        .in_ready(rdy_l), .ser_out(out_l), .ser_valid(v_l),
        .ser_first(f_l), .ser_last(l_l)
    );

    always #5 clk = ~clk;

    // Non-overlapping 101 detector on the MSB-first stream.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            det_n <= 0;
            det_h <= '0;
        end else if (v_m) begin
            if (det_n >= 2 && det_h == 2'b10 && out_m) begin
                det_hits <= det_hits + 1;
                det_n    <= 0;
                det_h    <= '0;
            end else begin
                det_h <= {det_h[0], out_m};
                det_n <= det_n + 1;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_word(input logic [W-1:0] w);
        for (int i = 0; i < W; i++) begin
            qm.push_back('{b: w[W-1-i], f: (i == 0), l: (i == W-1)});
            ql.push_back('{b: w[i],     f: (i == 0), l: (i == W-1)});
        end
    endtask

    task automatic check_outputs();
        logic er;
        er = rst && (qm.size() < W);
        chk("ready_msb", 32'(rdy_m), 32'(er));
        chk("ready_lsb", 32'(rdy_l), 32'(er));
        chk("valid_msb", 32'(v_m), 32'(exp_v));
        chk("valid_lsb", 32'(v_l), 32'(exp_v));
        chk("out_msb",   32'(out_m), 32'(exp_v & exp_m.b));
        chk("out_lsb",   32'(out_l), 32'(exp_v & exp_l.b));
        chk("first_msb", 32'(f_m), 32'(exp_v & exp_m.f));
        chk("first_lsb", 32'(f_l), 32'(exp_v & exp_l.f));
        chk("last_msb",  32'(l_m), 32'(exp_v & exp_m.l));
        chk("last_lsb",  32'(l_l), 32'(exp_v & exp_l.l));
    endtask

    // One clock: drive inputs, advance the model at the edge, check mid-cycle.
    task automatic step(input logic v, input logic [W-1:0] d);
        logic acc;
        in_valid = v;
        in_data  = d;
        acc = v && rst && (qm.size() < W);
        @(posedge clk);
        if (!rst) begin
            qm.delete();
            ql.delete();
            exp_v = 1'b0;
        end else begin
            if (acc) push_word(d);
            if (qm.size() > 0) begin
                exp_m = qm.pop_front();
                exp_l = ql.pop_front();
                exp_v = 1'b1;
            end else begin
                exp_v = 1'b0;
            end
        end
        @(negedge clk);
        if (v_m) got_m = {got_m[W-2:0], out_m};
        if (v_l) got_l = {out_l, got_l[W-1:1]};
        check_outputs();
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_ready"}, 32'({rdy_m, rdy_l}), 32'd0);
        chk({tag, "_outs"},  32'({out_m, v_m, f_m, l_m, out_l, v_l, f_l, l_l}), 32'd0);
    endtask

    initial begin
        logic [W-1:0] words[3];
        int           wi;
        int           guard;
        int           hits0;
        logic         acc_pred;

        // Reset held with valid input: nothing accepted, everything low.
        rst = 1'b0;
        for (int i = 0; i < 3; i++) step(1'b1, 8'hC3);
        check_all_zero("reset");
        rst = 1'b1;
        #1;
        chk("ready_after_release", 32'({rdy_m, rdy_l}), 32'b11);

        // Single word.
        got_m = '0;
        got_l = '0;
        step(1'b1, 8'hA5);
        for (int i = 0; i < 9; i++) step(1'b0, 8'h00);
        chk("a5_word_msb", 32'(got_m), 32'h A5);
        chk("a5_word_lsb", 32'(got_l), 32'h A5);

        // LSB-first single bit pattern.
        got_m = '0;
        got_l = '0;
        step(1'b1, 8'h01);
        for (int i = 0; i < 9; i++) step(1'b0, 8'h00);
        chk("w01_word_lsb", 32'(got_l), 32'h01);
        chk("w01_word_msb", 32'(got_m), 32'h01);

        // Back-to-back with valid held high.
        words[0] = 8'hA5;
        words[1] = 8'h5A;
        words[2] = 8'hFF;
        wi = 0;
        guard = 0;
        while (wi < 3 && guard < 100) begin
            acc_pred = rst && (qm.size() < W);
            step(1'b1, words[wi]);
            if (acc_pred) wi++;
            guard++;
        end
        chk("b2b_all_accepted", 32'(wi), 32'd3);
        for (int i = 0; i < 3 * W; i++) step(1'b0, 8'h00);

        // Reset mid-word with a second word in hold.
        step(1'b1, 8'hA5);
        step(1'b1, 8'h3C);
        step(1'b0, 8'h00);
        step(1'b0, 8'h00);
        #2;
        rst = 1'b0;
        #1;
        check_all_zero("midreset");
        qm.delete();
        ql.delete();
        exp_v = 1'b0;
        step(1'b1, 8'h77);
        step(1'b1, 8'h77);
        rst = 1'b1;
        #1;
        chk("ready_after_midreset", 32'({rdy_m, rdy_l}), 32'b11);
        for (int i = 0; i < 12; i++) step(1'b0, 8'h00);

        // Detector end-to-end.
        hits0 = det_hits;
        step(1'b1, 8'hA5);
        for (int i = 0; i < 10; i++) step(1'b0, 8'h00);
        chk("detector_hits_a5", 32'(det_hits - hits0), 32'd2);

        // Randomized traffic.
        for (int i = 0; i < 500; i++) begin
            step($urandom_range(0, 3) != 0, W'($urandom));
        end
        for (int i = 0; i < 2 * W + 2; i++) step(1'b0, 8'h00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/serial_bit_feeder.md
# serial_bit_feeder

Parallel-to-serial front end for the bit-serial sequence detectors in the FSM library (101 detectors, overlapping and non-overlapping). Accepts WIDTH-bit words on a valid/ready handshake and emits them one bit per clock, with per-bit valid and word framing strobes. A one-word holding buffer lets consecutive words stream with no idle cycle between them. The serial output drives a detector's data input directly.

## Interface
- WIDTH, 8: word width in bits; must be ≥ 2.
- MSB_FIRST, 1: 1 = bit WIDTH-1 is sent first; 0 = bit 0 is sent first.

- clk  in  1  clock; all state updates on its rising edge.
- rst  in  1  reset, asynchronous, active-low. One clock; reset is asynchronous and active-low.
- in_data  in  WIDTH  parallel word.
- in_valid  in  1  in_data is valid.
- in_ready  out  1  block accepts a word this cycle. Transfer occurs when in_valid & in_ready at a rising edge.
- ser_out  out  1  current serial bit. Registered.
- ser_valid  out  1  ser_out carries a real bit. Registered.
- ser_first  out  1  ser_out is the first bit of a word. Registered.
- ser_last  out  1  ser_out is the last bit of a word. Registered.

## Operation
- Storage:
  - shift register `sh` (WIDTH).
  - bit counter `cnt`, $clog2(WIDTH) bits.
  - holding register `hold` (WIDTH) with flag `hold_full`.
  - state ∈ {IDLE, SHIFT}.
- Reset (rst low, asynchronous):
  - state = IDLE; cnt = 0; hold_full = 0.
  - ser_out, ser_valid, ser_first, ser_last = 0.
  - in_ready = 0 while rst is low.
- in_ready = rst & ~hold_full (combinational).
- Shifter free at next edge (`free`) when state == IDLE, or state == SHIFT with cnt == WIDTH-1.
- Load priority at each edge when `free`:
  1. hold_full → sh ← hold, hold_full ← 0.
  2. else accepted word → sh ← in_data.
  3. else state ← IDLE.
- A load sets cnt ← 0 and state ← SHIFT.
- An accepted word that is not loaded per the priority above is written to hold, and hold_full ← 1.
- Never-violated invariant: a word is accepted only when hold is empty.
- SHIFT, per cycle:
  - Emit bit `cnt` of the word in the configured order; cnt ← cnt + 1.
  - ser_first = (cnt == 0); ser_last = (cnt == WIDTH-1).
- IDLE: ser_valid = ser_first = ser_last = 0; ser_out = 0.
- No bit is ever dropped, duplicated or reordered. Words are emitted in acceptance order.

## Timing
- Latency: word accepted at edge N (shifter idle) → first bit valid in the cycle after edge N. Last bit follows at edge N+WIDTH-1.
- Back-to-back traffic: the ser_last of word k is immediately followed by the ser_first of word k+1, with no ser_valid gap, provided word k+1 was accepted no later than the edge that ends word k's last bit.
- Simultaneous events:
  - Last bit with hold full: hold moves to the shifter, and in_ready rises the following cycle.
  - Last bit with hold empty and a word accepted: the word goes directly to the shifter.
- Throughput: one word per WIDTH cycles sustained. At most two words are resident (sh + hold).
- Reset mid-word: outputs clear asynchronously, and the in-flight and held words are discarded. After rst deasserts, the first edge sees IDLE with in_ready = 1.

## Structure
- Shared package `ser_pkg`:
  - state enum {IDLE, SHIFT}.
  - default WIDTH constant.
  - bit-order localparams.
- Single module. No sub-module is needed; the hold buffer is a register plus flag, kept inline.

## Test plan
- Reset: hold rst low for 3 cycles with in_valid = 1 → all outputs 0, in_ready = 0, no word accepted. After release, in_ready = 1.
- Single word, MSB_FIRST = 1: in_data = 8'hA5 → ser_out = 1,0,1,0,0,1,0,1 over 8 cycles; ser_first on cycle 1, ser_last on cycle 8; then ser_valid = 0.
- Back-to-back: 8'hA5, 8'h5A, 8'hFF with in_valid held high → 24 contiguous valid bits in order. in_ready drops when hold fills and rises one cycle after each ser_last.
- LSB-first: MSB_FIRST = 0, in_data = 8'h01 → ser_out = 1 followed by seven 0s.
- Reset mid-word: assert rst during bit 4 of 8'hA5 with 8'h3C in hold → outputs clear in the same cycle. After release, no stale bits appear and hold_full = 0.
- End-to-end: stream 8'hA5 into a 101 non-overlapping detector → detector flags exactly at the expected bit positions.
